// File: rtl/face_coords_uart_tx.sv
// face_coords_uart_tx
// Return-path UART transmitter for face detections. Each face_coords_ready
// strobe queues {pyramid, row[15:0], col[15:0]} in a small FIFO; queued entries
// are sent as framed 8N1 byte packets: A5, {0,pyr}, row hi/lo, col hi/lo,
// and optionally an XOR checksum byte.
//
// Build option: define FACE_TX_CHECKSUM_EN to append the checksum byte B6.
//
// Ports:
//   clock              system clock, rising edge
//   reset              asynchronous active-high reset, clears all state
//   face_coords        [0] = row, [1] = col; only bits [15:0] are sent
//   face_coords_ready  one detection per cycle high
//   pyramid_number     pyramid level of the detection
//   clear_overflow     synchronous clear of fifo_overflow / drop_count
//   tx                 UART serial out, idle high
//   busy               frame on the line or FIFO non-empty
//   fifo_overflow      sticky drop flag
//   drop_count         saturating count of dropped detections
module face_coords_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned FIFO_DEPTH   = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [1:0][31:0] face_coords,
    input  logic             face_coords_ready,
    input  logic [3:0]       pyramid_number,
    input  logic             clear_overflow,
    output logic             tx,
    output logic             busy,
    output logic             fifo_overflow,
    output logic [15:0]      drop_count
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned PW    = PTR_W + 1;
`ifdef FACE_TX_CHECKSUM_EN
    localparam logic [2:0] LAST_BYTE = 3'd6;
`else
    localparam logic [2:0] LAST_BYTE = 3'd5;
`endif

    typedef struct packed {
        logic [3:0]  pyramid;
        logic [15:0] row;
        logic [15:0] col;
    } det_t;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    // Byte idx of the frame built from a latched detection.
    function automatic logic [7:0] frame_byte(input det_t f, input logic [2:0] idx);
        logic [7:0] b;
        case (idx)
            3'd0:    b = 8'hA5;
            3'd1:    b = {4'h0, f.pyramid};
            3'd2:    b = f.row[15:8];
            3'd3:    b = f.row[7:0];
            3'd4:    b = f.col[15:8];
            3'd5:    b = f.col[7:0];
`ifdef FACE_TX_CHECKSUM_EN
            3'd6:    b = {4'h0, f.pyramid} ^ f.row[15:8] ^ f.row[7:0] ^ f.col[15:8] ^ f.col[7:0];
`endif
            default: b = 8'hFF;
        endcase
        frame_byte = b;
    endfunction

    state_t           state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic [2:0]       bit_idx, bit_d;
    logic [2:0]       byte_idx, byte_d;
    det_t             frame, frame_d;
    logic [PW-1:0]    wr_ptr, wr_d, rd_ptr, rd_d;
    det_t             mem [FIFO_DEPTH];
    det_t             head, in_det;
    logic             empty, full, pop, push, drop, baud_done;
    logic             tx_d, busy_d, ovf_d;
    logic [15:0]      drop_d;
    logic [7:0]       cur_byte;
    logic             unused_hi;

    assign unused_hi = ^{face_coords[0][31:16], face_coords[1][31:16]};
    assign in_det    = '{pyramid: pyramid_number, row: face_coords[0][15:0], col: face_coords[1][15:0]};
    assign head      = mem[rd_ptr[PTR_W-1:0]];
    assign empty     = (wr_ptr == rd_ptr);
    // Extra pointer bit distinguishes full from empty.
    assign full      = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) && (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign baud_done = (cnt == CNT_W'(CLKS_PER_BIT - 1));

    // Serializer next state; tx is derived from the next state so it is registered.
    always_comb begin : fsm_next
        state_d = state;
        cnt_d   = cnt + CNT_W'(1);
        bit_d   = bit_idx;
        byte_d  = byte_idx;
        frame_d = frame;
        pop     = 1'b0;
        case (state)
            IDLE: begin
                cnt_d = '0;
                if (!empty) begin
                    pop     = 1'b1;
                    frame_d = head;
                    byte_d  = 3'd0;
                    state_d = START;
                end
            end
            START: begin
                if (baud_done) begin
                    cnt_d   = '0;
                    bit_d   = 3'd0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (baud_done) begin
                    cnt_d = '0;
                    if (bit_idx == 3'd7) state_d = STOP;
                    else                 bit_d   = bit_idx + 3'd1;
                end
            end
            STOP: begin
                if (baud_done) begin
                    cnt_d = '0;
                    if (byte_idx != LAST_BYTE) begin
                        byte_d  = byte_idx + 3'd1;
                        state_d = START;
                    end else if (!empty) begin
                        // Chain straight into the next frame with no idle gap.
                        pop     = 1'b1;
                        frame_d = head;
                        byte_d  = 3'd0;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        cur_byte = frame_byte(frame_d, byte_d);
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = cur_byte[bit_d];
            default: tx_d = 1'b1;
        endcase
    end

    // FIFO push/drop resolution; a same-edge pop frees a slot for the push.
    always_comb begin : fifo_next
        push   = face_coords_ready && (!full || pop);
        drop   = face_coords_ready && full && !pop;
        wr_d   = push ? wr_ptr + PW'(1) : wr_ptr;
        rd_d   = pop  ? rd_ptr + PW'(1) : rd_ptr;
        busy_d = (state_d != IDLE) || (wr_d != rd_d);
        ovf_d  = fifo_overflow;
        drop_d = drop_count;
        // A drop coinciding with a clear wins.
        if (drop) begin
            ovf_d  = 1'b1;
            drop_d = clear_overflow ? 16'd1 :
                     (drop_count == 16'hFFFF) ? drop_count : drop_count + 16'd1;
        end else if (clear_overflow) begin
            ovf_d  = 1'b0;
            drop_d = 16'd0;
        end
    end

    always_ff @(posedge clock) begin : fifo_mem
        if (push) mem[wr_ptr[PTR_W-1:0]] <= in_det;
    end

    always_ff @(posedge clock or posedge reset) begin : regs
        if (reset) begin
            state         <= IDLE;
            cnt           <= '0;
            bit_idx       <= 3'd0;
            byte_idx      <= 3'd0;
            frame         <= '0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            tx            <= 1'b1;
            busy          <= 1'b0;
            fifo_overflow <= 1'b0;
            drop_count    <= 16'd0;
        end else begin
            state         <= state_d;
            cnt           <= cnt_d;
            bit_idx       <= bit_d;
            byte_idx      <= byte_d;
            frame         <= frame_d;
            wr_ptr        <= wr_d;
            rd_ptr        <= rd_d;
            tx            <= tx_d;
            busy          <= busy_d;
            fifo_overflow <= ovf_d;
            drop_count    <= drop_d;
        end
    end

endmodule

// File: tb/tb_face_coords_uart_tx.sv
// Bench for face_coords_uart_tx with CLKS_PER_BIT=4, FIFO_DEPTH=4.
// Expected bytes are queued at drive time; a UART decoder pops and compares.
module tb_face_coords_uart_tx;

    localparam int unsigned C = 4;
    localparam int unsigned D = 4;
`ifdef FACE_TX_CHECKSUM_EN
    localparam int unsigned NB = 7;
`else
    localparam int unsigned NB = 6;
`endif
    localparam int unsigned FRAME = NB * 10 * C;
    localparam int unsigned LIMIT = 8 * FRAME;

    logic             clock = 1'b0;
    logic             reset;
    logic [1:0][31:0] face_coords;
    logic             face_coords_ready;
    logic [3:0]       pyramid_number;
    logic             clear_overflow;
    logic             tx;
    logic             busy;
    logic             fifo_overflow;
    logic [15:0]      drop_count;

    logic [7:0] exp_q [$];
    int vectors = 0;
    int errors  = 0;
    int n;

    face_coords_uart_tx #(.CLKS_PER_BIT(C), .FIFO_DEPTH(D)) dut (
        .clock             (clock),
        .reset             (reset),
        .face_coords       (face_coords),
        .face_coords_ready (face_coords_ready),
        .pyramid_number    (pyramid_number),
        .clear_overflow    (clear_overflow),
        .tx                (tx),
        .busy              (busy),
        .fifo_overflow     (fifo_overflow),
        .drop_count        (drop_count)
    );

    always #5 clock = ~clock;

    function automatic void push_expected(input logic [31:0] row, input logic [31:0] col, input logic [3:0] pyr);
        logic [7:0] b [7];
        b[0] = 8'hA5;
        b[1] = {4'h0, pyr};
        b[2] = row[15:8];
        b[3] = row[7:0];
        b[4] = col[15:8];
        b[5] = col[7:0];
        b[6] = b[1] ^ b[2] ^ b[3] ^ b[4] ^ b[5];
        for (int i = 0; i < int'(NB); i++) exp_q.push_back(b[i]);
    endfunction

    // One-cycle detection strobe starting at a falling edge.
    task automatic drive_det(input logic [31:0] row, input logic [31:0] col, input logic [3:0] pyr, input bit expect_tx);
        face_coords[0]    = row;
        face_coords[1]    = col;
        pyramid_number    = pyr;
        face_coords_ready = 1'b1;
        if (expect_tx) push_expected(row, col, pyr);
        @(negedge clock);
        face_coords_ready = 1'b0;
    endtask

    // Cycles until busy drops, bounded by LIMIT.
    task automatic wait_idle(output int cycles);
        cycles = 0;
        while (busy && cycles < int'(LIMIT)) begin
            @(posedge clock);
            #1;
            cycles++;
        end
    endtask

    // UART decoder: sample each bit in its first cycle, abort a byte on reset.
    logic [7:0] mb;
    logic       mstop;
    bit         mok;
    initial begin : monitor
        forever begin
            @(negedge clock);
            if (!reset && tx === 1'b0) begin
                mok = 1'b1;
                for (int i = 0; i < 9; i++) begin
                    if (mok) begin
                        repeat (C) @(negedge clock);
                        if (reset)      mok   = 1'b0;
                        else if (i < 8) mb[i] = tx;
                        else            mstop = tx;
                    end
                end
                if (mok) begin
                    vectors++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL uart_byte: got unexpected byte %02h, required none", mb);
                    end else begin
                        logic [7:0] e;
                        e = exp_q.pop_front();
                        if (mb !== e || mstop !== 1'b1) begin
                            errors++;
                            $display("FAIL uart_byte: got %02h stop=%b, required %02h stop=1", mb, mstop, e);
                        end
                    end
                end
            end
        end
    end

    task automatic test_reset();
        vectors++;
        if ({tx, busy, fifo_overflow, drop_count} !== {1'b1, 1'b0, 1'b0, 16'd0}) begin
            errors++;
            $display("FAIL reset_state: tx=%b busy=%b ovf=%b cnt=%0d, required 1 0 0 0", tx, busy, fifo_overflow, drop_count);
        end
    endtask

    task automatic check_drained(input string name);
        vectors++;
        if (exp_q.size() != 0 || tx !== 1'b1) begin
            errors++;
            $display("FAIL %s_drained: %0d bytes outstanding tx=%b, required 0 and tx=1", name, exp_q.size(), tx);
        end
    endtask

    task automatic test_single();
        drive_det(32'h12, 32'h34, 4'd3, 1'b1);
        vectors++;
        if (busy !== 1'b1 || tx !== 1'b1) begin
            errors++;
            $display("FAIL single_push_edge: busy=%b tx=%b, required busy=1 tx=1", busy, tx);
        end
        @(negedge clock);
        vectors++;
        if (tx !== 1'b0) begin
            errors++;
            $display("FAIL single_latency: tx=%b one clock after push, required 0", tx);
        end
        wait_idle(n);
        vectors++;
        if (n != int'(FRAME)) begin
            errors++;
            $display("FAIL single_duration: %0d cycles, required %0d", n, FRAME);
        end
        repeat (2) @(negedge clock);
        check_drained("single");
    endtask

    task automatic test_back_to_back();
        drive_det(32'h0000_1111, 32'h0000_2222, 4'd1, 1'b1);
        drive_det(32'h0000_3333, 32'h0000_4444, 4'd2, 1'b1);
        drive_det(32'h0000_5555, 32'h0000_6666, 4'd4, 1'b1);
        wait_idle(n);
        vectors++;
        if (n != int'(3 * FRAME - 1)) begin
            errors++;
            $display("FAIL b2b_duration: %0d cycles, required %0d", n, 3 * FRAME - 1);
        end
        repeat (2) @(negedge clock);
        check_drained("b2b");
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 6; i++)
            drive_det(32'h100 + 32'(i), 32'h200 + 32'(i), 4'(i), i < 5);
        vectors++;
        if (fifo_overflow !== 1'b1 || drop_count !== 16'd1) begin
            errors++;
            $display("FAIL overflow_flag: ovf=%b cnt=%0d, required 1 1", fifo_overflow, drop_count);
        end
        wait_idle(n);
        vectors++;
        if (n != int'(5 * FRAME - 4)) begin
            errors++;
            $display("FAIL overflow_duration: %0d cycles, required %0d", n, 5 * FRAME - 4);
        end
        repeat (2) @(negedge clock);
        check_drained("overflow");
        clear_overflow = 1'b1;
        @(negedge clock);
        clear_overflow = 1'b0;
        vectors++;
        if (fifo_overflow !== 1'b0 || drop_count !== 16'd0) begin
            errors++;
            $display("FAIL overflow_clear: ovf=%b cnt=%0d, required 0 0", fifo_overflow, drop_count);
        end
    endtask

    task automatic test_full_boundary();
        for (int i = 0; i < 5; i++)
            drive_det(32'hA00 + 32'(i), 32'hB00 + 32'(i), 4'(i + 8), 1'b1);
        // Land the next strobe on the edge that pops frame 2 while full.
        repeat (FRAME - 4) @(negedge clock);
        drive_det(32'hCAFE, 32'hBEEF, 4'hF, 1'b1);
        vectors++;
        if (fifo_overflow !== 1'b0 || drop_count !== 16'd0) begin
            errors++;
            $display("FAIL boundary_no_drop: ovf=%b cnt=%0d, required 0 0", fifo_overflow, drop_count);
        end
        wait_idle(n);
        vectors++;
        if (n != int'(5 * FRAME)) begin
            errors++;
            $display("FAIL boundary_duration: %0d cycles, required %0d", n, 5 * FRAME);
        end
        repeat (2) @(negedge clock);
        check_drained("boundary");
    endtask

    task automatic test_reset_mid_frame();
        drive_det(32'h5668, 32'h9ABC, 4'd7, 1'b1);
        drive_det(32'h7777, 32'h8888, 4'd6, 1'b1);
        // First cycle of B3 (0x68) bit 4, which is a 0.
        repeat (35 * C) @(negedge clock);
        vectors++;
        if (tx !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_position: tx=%b before reset, required 0", tx);
        end
        #2;
        reset = 1'b1;
        exp_q.delete();
        #1;
        vectors++;
        if (tx !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_async: tx=%b busy=%b, required 1 0", tx, busy);
        end
        repeat (3 * C) @(negedge clock);
        reset = 1'b0;
        repeat (3 * C) @(negedge clock);
        vectors++;
        if (tx !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_flushed: tx=%b busy=%b, required 1 0", tx, busy);
        end
        drive_det(32'h0042, 32'h0024, 4'd5, 1'b1);
        @(negedge clock);
        wait_idle(n);
        vectors++;
        if (n != int'(FRAME)) begin
            errors++;
            $display("FAIL reset_mid_clean: %0d cycles, required %0d", n, FRAME);
        end
        repeat (2) @(negedge clock);
        check_drained("reset_mid");
    endtask

    task automatic test_truncation();
        drive_det(32'h0001_FFFF, 32'hABCD_1234, 4'hA, 1'b1);
        @(negedge clock);
        wait_idle(n);
        vectors++;
        if (n != int'(FRAME)) begin
            errors++;
            $display("FAIL trunc_duration: %0d cycles, required %0d", n, FRAME);
        end
        repeat (2) @(negedge clock);
        check_drained("trunc");
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin : main
        reset             = 1'b1;
        face_coords       = '0;
        face_coords_ready = 1'b0;
        pyramid_number    = 4'd0;
        clear_overflow    = 1'b0;
        repeat (3) @(negedge clock);
        test_reset();
        reset = 1'b0;
        @(negedge clock);
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_full_boundary();
        test_reset_mid_frame();
        test_truncation();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
